// File: rtl/evm_cipher_engine.sv
// Sequential vote-record cipher: ROUNDS key-dependent xor/rotate rounds, one per clock,
// encrypt or decrypt, result returned with a CRC-8 of the plaintext over valid/ready.
module evm_cipher_engine #(
  parameter int unsigned DATA_W = 80,
  parameter int unsigned KEY_W  = 64,
  parameter int unsigned ROUNDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic [KEY_W-1:0]  master_key,
  input  logic [KEY_W-1:0]  baby_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [7:0]        crc,
  output logic              key_weak,
  output logic              busy
);

  localparam int unsigned CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] x_q, x_d;
  logic [KEY_W-1:0]  fk_q, fk_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        crc_pt_q, crc_pt_d;
  logic              in_ready_d, out_valid_d, key_weak_d, busy_d;
  logic [DATA_W-1:0] data_out_d;
  logic [7:0]        crc_d;

  logic [CNT_W-1:0]  r_sel;
  logic [KEY_W-1:0]  k_r;
  logic [DATA_W-1:0] ks_r, x_nx;
  logic [4:0]        amt_r;
  logic              last;
  logic [7:0]        crc_in, crc_nx;

  function automatic logic [KEY_W-1:0] key_rotl(input logic [KEY_W-1:0] k, input int unsigned sh);
    logic [2*KEY_W-1:0] t;
    t = {k, k} << sh;
    return t[2*KEY_W-1 -: KEY_W];
  endfunction

  // Keystream is the round key repeated MSB-first and cut to the record width
  function automatic logic [DATA_W-1:0] key_stream(input logic [KEY_W-1:0] k);
    logic [DATA_W-1:0] ks;
    ks = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      ks[DATA_W-1-i] = k[KEY_W-1-(i % KEY_W)];
    end
    return ks;
  endfunction

  function automatic logic [DATA_W-1:0] rotl_data(input logic [DATA_W-1:0] x, input int unsigned s);
    logic [2*DATA_W-1:0] t;
    t = {x, x} << (s % DATA_W);
    return t[2*DATA_W-1 -: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rotr_data(input logic [DATA_W-1:0] x, input int unsigned s);
    logic [2*DATA_W-1:0] t;
    t = {x, x} >> (s % DATA_W);
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [7:0] crc8(input logic [DATA_W-1:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Decrypt walks the round keys in reverse order
  assign r_sel  = mode_q ? (CNT_W'(ROUNDS - 1) - cnt_q) : cnt_q;
  assign k_r    = key_rotl(fk_q, (32'(r_sel) * 32'd8) % KEY_W);
  assign ks_r   = key_stream(k_r);
  assign amt_r  = 5'(k_r[3:0]) + 5'd1;
  assign x_nx   = mode_q ? (rotr_data(x_q, 32'(amt_r)) ^ ks_r)
                         : rotl_data(x_q ^ ks_r, 32'(amt_r));
  assign last   = (cnt_q == CNT_W'(ROUNDS - 1));
  assign crc_in = crc8(data_in);
  assign crc_nx = crc8(x_nx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x_q       <= '0;
      fk_q      <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      crc_pt_q  <= 8'h00;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      crc       <= 8'h00;
      key_weak  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      x_q       <= x_d;
      fk_q      <= fk_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      crc_pt_q  <= crc_pt_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      data_out  <= data_out_d;
      crc       <= crc_d;
      key_weak  <= key_weak_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_nx    = state;
    x_d         = x_q;
    fk_d        = fk_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    crc_pt_d    = crc_pt_q;
    out_valid_d = out_valid;
    data_out_d  = data_out;
    crc_d       = crc;
    key_weak_d  = key_weak;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_d      = data_in;
          fk_d     = master_key ^ baby_key;
          mode_d   = mode;
          cnt_d    = '0;
          crc_pt_d = crc_in;
          state_nx = RUN;
        end
      end
      RUN: begin
        x_d   = x_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          data_out_d  = x_nx;
          crc_d       = mode_q ? crc_nx : crc_pt_q;
          key_weak_d  = (fk_q == '0);
          out_valid_d = 1'b1;
          state_nx    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    in_ready_d = (state_nx == IDLE);
    busy_d     = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_evm_cipher_engine.sv
// Scoreboard bench for evm_cipher_engine: default build against a bit-level model,
// plus two extra parameterisations checked for round trip and latency.
module tb_evm_cipher_engine;

  localparam int unsigned DW = 80;
  localparam int unsigned KW = 64;
  localparam int unsigned RN = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [7:0]    c;
    logic          w;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, mode, out_valid, out_ready, key_weak, busy;
  logic [DW-1:0] data_in, data_out;
  logic [KW-1:0] master_key, baby_key;
  logic [7:0]    crc;

  logic        a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready, a_key_weak, a_busy;
  logic [31:0] a_data_in, a_data_out;
  logic [15:0] a_mk, a_bk;
  logic [7:0]  a_crc;

  logic         b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_key_weak, b_busy;
  logic [127:0] b_data_in, b_data_out;
  logic [63:0]  b_mk, b_bk;
  logic [7:0]   b_crc;

  evm_cipher_engine #(.DATA_W(DW), .KEY_W(KW), .ROUNDS(RN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .data_in(data_in), .master_key(master_key), .baby_key(baby_key),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .crc(crc),
    .key_weak(key_weak), .busy(busy));

  evm_cipher_engine #(.DATA_W(32), .KEY_W(16), .ROUNDS(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .mode(a_mode),
    .data_in(a_data_in), .master_key(a_mk), .baby_key(a_bk),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_data_out), .crc(a_crc),
    .key_weak(a_key_weak), .busy(a_busy));

  evm_cipher_engine #(.DATA_W(128), .KEY_W(64), .ROUNDS(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .mode(b_mode),
    .data_in(b_data_in), .master_key(b_mk), .baby_key(b_bk),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out), .crc(b_crc),
    .key_weak(b_key_weak), .busy(b_busy));

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  function automatic logic [7:0] m_crc(input logic [127:0] d, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Reference encrypt for the 80/64/4 build, one-bit rotations at a time
  function automatic logic [DW-1:0] m_enc(input logic [DW-1:0] d, input logic [KW-1:0] fk);
    logic [DW-1:0] x;
    logic [KW-1:0] k;
    x = d;
    for (int r = 0; r < int'(RN); r++) begin
      k = fk;
      for (int j = 0; j < (8 * r) % int'(KW); j++) k = {k[KW-2:0], k[KW-1]};
      x = x ^ {k, k[KW-1 -: DW-KW]};
      for (int j = 0; j < int'(k[3:0]) + 1; j++) x = {x[DW-2:0], x[DW-1]};
    end
    return x;
  endfunction

  task automatic send(input logic m, input logic [DW-1:0] d, input logic [KW-1:0] mk,
                      input logic [KW-1:0] bk, input exp_t e);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    if (!in_ready) chk("in_ready_wait", 128'(in_ready), 128'(1));
    mode = m; data_in = d; master_key = mk; baby_key = bk; in_valid = 1'b1;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; mode = ~m; data_in = rnd80();
    master_key = ~mk; baby_key = {$urandom, $urandom};
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < int'(RN) + 20) begin @(negedge clk); cyc++; end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (q.size() == 0) chk({tag, "_sb_empty"}, 128'(q.size()), 128'(1));
    else begin
      e = q.pop_front();
      chk({tag, "_data"}, 128'(data_out), 128'(e.d));
      chk({tag, "_crc"},  128'(crc),      128'(e.c));
      chk({tag, "_weak"}, 128'(key_weak), 128'(e.w));
    end
  endtask

  task automatic receive(input string tag);
    int cyc;
    wait_out(cyc);
    chk({tag, "_lat"}, 128'(cyc), 128'(RN));
    pop_check(tag);
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    chk({tag, "_rdy_hold"}, 128'(in_ready), 128'(0));
    @(negedge clk);
    chk({tag, "_ov_drop"}, 128'(out_valid), 128'(0));
    chk({tag, "_rdy_back"}, 128'(in_ready), 128'(1));
  endtask

  task automatic xact(input string tag, input logic m, input logic [DW-1:0] d,
                      input logic [KW-1:0] mk, input logic [KW-1:0] bk, input exp_t e);
    send(m, d, mk, bk, e);
    receive(tag);
  endtask

  task automatic run_a(input logic m, input logic [31:0] d, input logic [15:0] mk,
                       input logic [15:0] bk, output logic [31:0] r, output logic [7:0] c,
                       output int lat);
    int w;
    w = 0;
    while (!a_in_ready && w < 20) begin @(negedge clk); w++; end
    a_mode = m; a_data_in = d; a_mk = mk; a_bk = bk; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; a_data_in = ~d; a_mk = ~mk; a_mode = ~m;
    lat = 0;
    while (!a_out_valid && lat < 40) begin @(negedge clk); lat++; end
    r = a_data_out; c = a_crc;
    @(negedge clk);
  endtask

  task automatic run_b(input logic m, input logic [127:0] d, input logic [63:0] mk,
                       input logic [63:0] bk, output logic [127:0] r, output logic [7:0] c,
                       output int lat);
    int w;
    w = 0;
    while (!b_in_ready && w < 20) begin @(negedge clk); w++; end
    b_mode = m; b_data_in = d; b_mk = mk; b_bk = bk; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0; b_data_in = ~d; b_mk = ~mk; b_mode = ~m;
    lat = 0;
    while (!b_out_valid && lat < 40) begin @(negedge clk); lat++; end
    r = b_data_out; c = b_crc;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0]  d, cph, dv;
    logic [KW-1:0]  mk, bk;
    logic [7:0]     cv, c1, c2;
    logic [31:0]    ad, ac, ap;
    logic [15:0]    amk, abk;
    logic [127:0]   bd, bc, bp;
    int             cyc, l1, l2;
    logic           seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
    data_in = '0; master_key = '0; baby_key = '0;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_mode = 1'b0; a_data_in = '0; a_mk = '0; a_bk = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_mode = 1'b0; b_data_in = '0; b_mk = '0; b_bk = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_data", 128'(data_out), 128'(0));
    chk("rst_crc", 128'(crc), 128'(0));
    chk("rst_weak", 128'(key_weak), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_rdy", 128'(in_ready), 128'(1));

    // Zero final key: four plain rotl-by-1 of the record
    xact("weak", 1'b0, 80'h1, 64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5,
         '{d: 80'h10, c: 8'h07, w: 1'b1});
    xact("zero", 1'b0, '0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
         '{d: '0, c: 8'h00, w: 1'b1});

    for (int n = 0; n < 1000; n++) begin
      do begin
        mk = {$urandom, $urandom}; bk = {$urandom, $urandom};
      end while ((mk ^ bk) == '0);
      d   = rnd80();
      cph = m_enc(d, mk ^ bk);
      cv  = m_crc(128'(d), 80);
      xact("enc", 1'b0, d, mk, bk, '{d: cph, c: cv, w: 1'b0});
      xact("dec", 1'b1, cph, mk, bk, '{d: d, c: cv, w: 1'b0});
    end

    // Backpressure: result must hold while the consumer stalls
    out_ready = 1'b0;
    d = rnd80(); mk = {$urandom, $urandom}; bk = {$urandom, $urandom};
    send(1'b0, d, mk, bk, '{d: m_enc(d, mk ^ bk), c: m_crc(128'(d), 80), w: ((mk ^ bk) == '0)});
    wait_out(cyc);
    chk("bp_lat", 128'(cyc), 128'(RN));
    pop_check("bp");
    dv = data_out; cv = crc;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1)); data_in = rnd80(); mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_data_hold", 128'(data_out), 128'(dv));
      chk("bp_crc_hold", 128'(crc), 128'(cv));
      chk("bp_ov_hold", 128'(out_valid), 128'(1));
      chk("bp_rdy_low", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ov_drop", 128'(out_valid), 128'(0));
    chk("bp_rdy_back", 128'(in_ready), 128'(1));
    @(negedge clk);
    chk("bp_no_accept", 128'(busy), 128'(0));

    // Reset while a record is in flight
    d = rnd80(); mk = {$urandom, $urandom}; bk = {$urandom, $urandom};
    send(1'b0, d, mk, bk, '{d: '0, c: 8'h00, w: 1'b0});
    q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ov", 128'(out_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_data", 128'(data_out), 128'(0));
    chk("mid_rst_crc", 128'(crc), 128'(0));
    chk("mid_rst_rdy", 128'(in_ready), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_rdy_back", 128'(in_ready), 128'(1));
    seen = 1'b0;
    for (int i = 0; i < int'(RN) + 3; i++) begin
      seen = seen | out_valid;
      @(negedge clk);
    end
    chk("mid_rst_no_pulse", 128'(seen), 128'(0));
    chk("sb_drained", 128'(q.size()), 128'(0));

    // 32/16/1 build
    run_a(1'b0, 32'h1, 16'h5A5A, 16'h5A5A, ac, c1, l1);
    chk("a_weak_data", 128'(ac), 128'(32'h2));
    chk("a_weak_lat", 128'(l1), 128'(1));
    for (int n = 0; n < 20; n++) begin
      ad = $urandom; amk = 16'($urandom); abk = 16'($urandom);
      run_a(1'b0, ad, amk, abk, ac, c1, l1);
      run_a(1'b1, ac, amk, abk, ap, c2, l2);
      chk("a_enc_lat", 128'(l1), 128'(1));
      chk("a_dec_lat", 128'(l2), 128'(1));
      chk("a_enc_crc", 128'(c1), 128'(m_crc(128'(ad), 32)));
      chk("a_roundtrip", 128'(ap), 128'(ad));
      chk("a_dec_crc", 128'(c2), 128'(c1));
    end

    // 128/64/16 build
    run_b(1'b0, 128'h1, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0F0F_0F0F_0F0F, bc, c1, l1);
    chk("b_weak_data", bc, 128'h1_0000);
    chk("b_weak_lat", 128'(l1), 128'(16));
    for (int n = 0; n < 20; n++) begin
      bd = {$urandom, $urandom, $urandom, $urandom};
      mk = {$urandom, $urandom}; bk = {$urandom, $urandom};
      run_b(1'b0, bd, mk, bk, bc, c1, l1);
      run_b(1'b1, bc, mk, bk, bp, c2, l2);
      chk("b_enc_lat", 128'(l1), 128'(16));
      chk("b_dec_lat", 128'(l2), 128'(16));
      chk("b_enc_crc", 128'(c1), 128'(m_crc(bd, 128)));
      chk("b_roundtrip", bp, bd);
      chk("b_dec_crc", 128'(c2), 128'(c1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
